// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control FSM: state is registered, outputs decode combinationally from state.
// Optional macro MC_CTRL_BNE_EN adds bne through the BRANCH state.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, next_state;
  logic   ir_write, pc_write, mem_write, reg_write, done;
  logic   branch, taken, set_illegal;

`ifdef MC_CTRL_BNE_EN
  logic is_bne;
  assign taken = is_bne ? ~Zero : Zero;
`else
  assign taken = Zero;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      Illegal <= 1'b0;
`ifdef MC_CTRL_BNE_EN
      is_bne  <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (set_illegal) Illegal <= 1'b1;
`ifdef MC_CTRL_BNE_EN
      // beq and bne differ only in Op[0]; latch it so BRANCH needs no re-decode
      if (state == DECODE) is_bne <= Op[0];
`endif
    end
  end

  always_comb begin
    next_state  = FETCH;
    IorD        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    done        = 1'b0;
    branch      = 1'b0;
    set_illegal = 1'b0;
    PCSrc       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = ALU_ADD;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB    = 2'b01;
        ir_write   = MemReady;
        pc_write   = MemReady;
        next_state = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       next_state = BRANCH;
`endif
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      set_illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD       = 1'b1;
        next_state = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        mem_write  = 1'b1;
        done       = MemReady;
        next_state = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA    = 1'b1;
        next_state = ALUWB;
        case (Funct)
          6'b100000: ALUControl = ALU_ADD;
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default: begin
            set_illegal = 1'b1;
            next_state  = FETCH;
          end
        endcase
      end
      ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        done       = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        done     = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // Reset kills every enable immediately, even though state already reads FETCH
  assign IRWrite   = ir_write & ~reset;
  assign PCEn      = (pc_write | (branch & taken)) & ~reset;
  assign MemWrite  = mem_write & ~reset;
  assign RegWrite  = reg_write & ~reset;
  assign InstrDone = done & ~reset;
  assign State     = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Random instruction stream against a latency/effect model; a negedge monitor scores each instruction.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero, MemReady;
  logic       IorD, MemWrite, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite, InstrDone, Illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .InstrDone(InstrDone), .Illegal(Illegal),
    .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010;

  typedef struct {
    int         cycles;
    int         irw;
    int         memw;
    int         regw;
    logic       regdst;
    logic       memtoreg;
    int         done;
    int         pcen;
    logic [1:0] pcsrc;
    logic       alu_v;
    logic [2:0] alu;
    logic       illegal;
  } rec_t;

  rec_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  bit   mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-instruction effects straight from the opcode table and zero-wait latencies
  function automatic rec_t model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input int fs, input int ms);
    rec_t e;
    int   post;
    logic br;
    e = '{cycles: 0, irw: 1, memw: 0, regw: 0, regdst: 0, memtoreg: 0, done: 0, pcen: 1,
          pcsrc: 2'b00, alu_v: 0, alu: 3'b000, illegal: 0};
    br = 0;
    case (op)
      LW:   begin post = 4 + ms; e.regw = 1; e.memtoreg = 1; e.done = 1; end
      SW:   begin post = 3 + ms; e.memw = ms + 1; e.done = 1; end
      ADDI: begin post = 3; e.regw = 1; e.done = 1; end
      J:    begin post = 2; e.pcen = 2; e.pcsrc = 2'b10; e.done = 1; end
      BEQ:  begin post = 2; br = 1; end
`ifdef MC_CTRL_BNE_EN
      BNE:  begin post = 2; br = 1; end
`endif
      RT: begin
        e.alu_v = 1;
        post = 3; e.regw = 1; e.regdst = 1; e.done = 1;
        case (fn)
          6'b100000: e.alu = 3'b010;
          6'b100010: e.alu = 3'b110;
          6'b100100: e.alu = 3'b000;
          6'b100101: e.alu = 3'b001;
          6'b101010: e.alu = 3'b111;
          default: begin
            post = 2; e.regw = 0; e.regdst = 0; e.done = 0; e.illegal = 1; e.alu = 3'b010;
          end
        endcase
      end
      default: begin post = 1; e.illegal = 1; end
    endcase
    if (br) begin
      e.alu_v = 1; e.alu = 3'b110; e.done = 1;
      if ((op == BNE) ? !z : z) begin e.pcen = 2; e.pcsrc = 2'b01; end
    end
    e.cycles = fs + 1 + post;
    return e;
  endfunction

  // Monitor: one record spans from a FETCH entry to the next FETCH entry
  rec_t       cur;
  bit         open;
  logic [3:0] prev_state;

  always @(negedge clk) begin
    if (!mon_en) begin
      open = 0;
      prev_state = 4'hF;
    end else begin
      if (State == 4'd0 && prev_state != 4'd0) begin
        if (open) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_instr: got record with no expectation queued");
          end else begin
            rec_t e;
            e = exp_q.pop_front();
            chk("cycles",   cur.cycles,   e.cycles);
            chk("irwrite",  cur.irw,      e.irw);
            chk("memwrite", cur.memw,     e.memw);
            chk("regwrite", cur.regw,     e.regw);
            chk("regdst",   cur.regdst,   e.regdst);
            chk("memtoreg", cur.memtoreg, e.memtoreg);
            chk("done",     cur.done,     e.done);
            chk("pcen",     cur.pcen,     e.pcen);
            chk("pcsrc",    cur.pcsrc,    e.pcsrc);
            chk("alu_v",    cur.alu_v,    e.alu_v);
            chk("alu",      cur.alu,      e.alu);
            chk("illegal",  Illegal,      e.illegal);
          end
        end
        open = 1;
        cur = '{cycles: 0, irw: 0, memw: 0, regw: 0, regdst: 0, memtoreg: 0, done: 0, pcen: 0,
                pcsrc: 2'b00, alu_v: 0, alu: 3'b000, illegal: 0};
      end
      prev_state = State;
      if (open) begin
        cur.cycles++;
        if (IRWrite)  cur.irw++;
        if (MemWrite) cur.memw++;
        if (RegWrite) begin cur.regw++; cur.regdst = RegDst; cur.memtoreg = MemtoReg; end
        if (InstrDone) cur.done++;
        if (PCEn) begin cur.pcen++; if (!IRWrite) cur.pcsrc = PCSrc; end
        if (ALUSrcA && ALUSrcB == 2'b00) begin cur.alu_v = 1; cur.alu = ALUControl; end
      end
    end
  end

  task automatic cyc(input logic mr);
    MemReady = mr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        sticky;
    logic [5:0]  op, fn;
    logic        z, mr;
    int          fs, ms, post, sel;
    rec_t        e;

    reset = 1; MemReady = 1; Op = SW; Funct = 6'b100000; Zero = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",    State,     4'd0);
    chk("rst_irwrite",  IRWrite,   1'b0);
    chk("rst_pcen",     PCEn,      1'b0);
    chk("rst_memwrite", MemWrite,  1'b0);
    chk("rst_regwrite", RegWrite,  1'b0);
    chk("rst_done",     InstrDone, 1'b0);
    chk("rst_illegal",  Illegal,   1'b0);
    chk("rst_alusrcb",  ALUSrcB,   2'b01);
    reset = 0;
    #3;
    chk("rel_irwrite", IRWrite, 1'b1);
    chk("rel_pcen",    PCEn,    1'b1);
    @(posedge clk); #1;
    cyc(0);
    cyc(0);
    #2;
    chk("sw_state",    State,    4'd5);
    chk("sw_memwrite", MemWrite, 1'b1);
    reset = 1;
    #1;
    chk("abort_memwrite", MemWrite, 1'b0);
    chk("abort_state",    State,    4'd0);
    @(posedge clk); #1;
    reset = 0; MemReady = 1;

    sticky = 0;
    mon_en = 1;
    for (int n = 0; n < 240; n++) begin
      sel = $urandom_range(0, (n < 120) ? 6 : 10);
      fn = 6'b100000;
      case (sel)
        0: op = LW;
        1: op = SW;
        2, 3: begin
          op = RT;
          case ($urandom_range(0, (n < 120) ? 4 : 5))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            4: fn = 6'b101010;
            default: fn = 6'b100111;
          endcase
        end
        4: op = BEQ;
        5: op = ADDI;
        6: op = J;
        7, 8: op = BNE;
        9: op = 6'b111111;
        default: op = 6'b001101;
      endcase
      z  = 1'($urandom_range(0, 1));
      fs = $urandom_range(0, 2);
      ms = $urandom_range(0, 3);
      e = model(op, fn, z, fs, ms);
      sticky = sticky | e.illegal;
      e.illegal = sticky;
      exp_q.push_back(e);
      Op = op; Funct = fn; Zero = z;
      repeat (fs) cyc(0);
      cyc(1);
      post = e.cycles - fs - 1;
      for (int k = 0; k < post; k++) begin
        if ((op == LW || op == SW) && k >= 2 && k < 2 + ms) mr = 0;
        else if ((op == LW || op == SW) && k == 2 + ms) mr = 1;
        else mr = 1'($urandom_range(0, 1));
        Zero = (k == post - 1) ? z : 1'($urandom_range(0, 1));
        if (op == BEQ || op == BNE) Zero = z;
        cyc(mr);
      end
    end
    repeat (3) cyc(0);
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 0;
    chk("illegal_sticky_end", Illegal, sticky);
    reset = 1;
    #1;
    chk("illegal_cleared", Illegal, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle MIPS core. Single-cycle `Data_path` flags are kept but reused across several cycles per instruction, sharing one memory for instruction and data and one ALU for PC increment, address and branch-target arithmetic. Decodes `Op`/`Funct` from the instruction register and `Zero` from the ALU. Drives every datapath select and write enable, with wait states for a handshaked memory.

## Interface
- No parameters; fixed 32-bit MIPS datapath, 4-bit state encoding.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; forces state to FETCH.
- `Op` in 6: Instr[31:26] from instruction register.
- `Funct` in 6: Instr[5:0].
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completes the current access this cycle.
- `IorD` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: instruction register load.
- `PCEn` out 1: PC load, equal to `PCWrite | (Branch & taken)`.
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `ALUSrcA` out 1: 0 = PC, 1 = reg A.
- `ALUSrcB` out 2: 00 = reg B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `RegDst` out 1: 0 = rt, 1 = rd.
- `MemtoReg` out 1: 0 = ALUOut, 1 = data register.
- `RegWrite` out 1: register file write enable.
- `InstrDone` out 1: one-cycle pulse in the final cycle of each retired instruction.
- `Illegal` out 1: sticky flag set on an unsupported Op/Funct; cleared only by reset.
- `State` out 4: current state, for debug.

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Codes 12–15 are unused; they go to FETCH next cycle with all enables 0.
- FETCH:
  - Outputs IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00.
  - IRWrite and PCWrite assert only while MemReady=1.
  - Goes to DECODE on MemReady=1; otherwise stays in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (computes branch target). Next state by Op:
  - 100011 lw, 101011 sw → MEMADR.
  - 000000 R-type → EXEC.
  - 000100 beq → BRANCH.
  - 001000 addi → ADDIEX.
  - 000010 j → JUMP.
  - Anything else → FETCH, sets Illegal, no InstrDone.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1; waits for MemReady, then → MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone; → FETCH.
- MEMWR: IorD=1, MemWrite=1 held until MemReady=1; then InstrDone, → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUControl by Funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Other Funct: Illegal set, → FETCH with no writes.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, InstrDone; → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1, taken=Zero, InstrDone; → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add; → ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone; → FETCH.
- JUMP: PCSrc=10, PCWrite=1, InstrDone; → FETCH.
- Outputs not listed for a state are 0 (selects 0, ALUControl=010).

## Timing
- State is registered; outputs are combinational from State. Only FETCH/MEMRD/MEMWR outputs also depend on MemReady.
- Zero-wait latencies (cycles): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each MemReady=0 cycle adds 1.
- While reset is high: State=0, Illegal=0, and PCEn, IRWrite, MemWrite, RegWrite, InstrDone all 0. Other outputs take FETCH values.
- Reset asserted mid-instruction: enables drop in the same cycle (asynchronous). After release, execution resumes in FETCH with no partial write.
- Reset release: first FETCH cycle is the first clk edge after deassertion.
- MemReady high in any state other than FETCH/MEMRD/MEMWR is ignored.

## Configuration
- `MC_CTRL_BNE_EN` defined:
  - Op 000101 (bne) decodes to BRANCH; taken = ~Zero for bne, Zero for beq.
  - beq/bne are distinguished by an Op bit captured in DECODE.
- `MC_CTRL_BNE_EN` undefined: Op 000101 is illegal (sets Illegal, → FETCH).

## Test plan
- Reset: reset=1 for 3 cycles with MemReady=1 → State=0, all enables 0, Illegal=0. Release → IRWrite=PCEn=1 on the next cycle.
- lw, Op=100011, MemReady tied 1 → states 0,1,2,3,4. RegWrite=1 and MemtoReg=1 in state 4; InstrDone once.
- sw with MemReady=0 for 2 cycles in MEMWR → MemWrite high for 3 cycles, InstrDone on the third, then FETCH.
- R-type sub, Funct=100010 → ALUControl=110 in EXEC. RegWrite=1, RegDst=1 in ALUWB. Total 4 cycles.
- beq with Zero=1 → PCEn=1, PCSrc=01 in BRANCH. With Zero=0 → PCEn=0. With the macro: bne inverts both results.
- Op=111111 → DECODE goes to FETCH; Illegal=1 and stays 1 through later instructions until reset; no write enable asserts.
